// File: rtl/jump_control_pkg.sv
// Shared opcode map and branch-condition types for jump_control.
// Optional stats counter is enabled by JUMP_CONTROL_STATS_EN.
package jump_control_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_BR   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_B    = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_BLTZ = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_BZ   = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_BL   = 6'b001001;
    localparam logic [OPCODE_W-1:0] OP_BNZ  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_BGTZ = 6'b001011;
    localparam logic [OPCODE_W-1:0] OP_BGEZ = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_BCY  = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_BNCY = 6'b001110;

    typedef enum logic [3:0] {
        COND_NONE,
        COND_ALWAYS,
        COND_SIGN,
        COND_ZERO,
        COND_NZERO,
        COND_GTZ,
        COND_GEZ,
        COND_CARRY,
        COND_NCARRY
    } cond_e;

    function automatic logic cond_met(
        input cond_e c,
        input logic  zero,
        input logic  sign,
        input logic  carry
    );
        logic r;
        r = 1'b0;
        unique case (c)
            COND_ALWAYS: r = 1'b1;
            COND_SIGN:   r = sign;
            COND_ZERO:   r = zero;
            COND_NZERO:  r = ~zero;
            COND_GTZ:    r = ~sign & ~zero;
            COND_GEZ:    r = ~sign;
            COND_CARRY:  r = carry;
            COND_NCARRY: r = ~carry;
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jump_cond_decode.sv
// Opcode to branch-condition decoder for jump_control.
// Purely combinational; unknown opcodes decode as non-branch.
module jump_cond_decode
    import jump_control_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output cond_e               cond,
    output logic                is_branch
);

    always_comb begin
        cond      = COND_NONE;
        is_branch = 1'b1;
        case (opcode)
            OP_BR:   cond = COND_ALWAYS;
            OP_B:    cond = COND_ALWAYS;
            OP_BLTZ: cond = COND_SIGN;
            OP_BZ:   cond = COND_ZERO;
            OP_BL:   cond = COND_ALWAYS;
            OP_BNZ:  cond = COND_NZERO;
            OP_BGTZ: cond = COND_GTZ;
            OP_BGEZ: cond = COND_GEZ;
            OP_BCY:  cond = COND_CARRY;
            OP_BNCY: cond = COND_NCARRY;
            default: begin
                cond      = COND_NONE;
                is_branch = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/jump_control.sv
// Branch resolution: decides PC redirect from opcode and ALU flags.
// Define JUMP_CONTROL_STATS_EN to add the saturating taken_count port.
module jump_control
    import jump_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                sign,
    input  logic                carry,
    input  logic                stall,
    output logic                validJump,
    output logic                is_branch,
`ifdef JUMP_CONTROL_STATS_EN
    output logic [CNT_W-1:0]    taken_count,
`endif
    output logic                validJump_q
);

    cond_e cond;
    logic  br;

    jump_cond_decode u_dec (
        .opcode    (opcode),
        .cond      (cond),
        .is_branch (br)
    );

    assign is_branch = br;
    assign validJump = br & ~stall
                     & cond_met(cond, zero, sign, carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validJump_q <= 1'b0;
        end else begin
            validJump_q <= validJump;
        end
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("jump_control: CNT_W must be at least 1");
    end

`ifdef JUMP_CONTROL_STATS_EN
    // Saturate rather than wrap so trace tools never see a false low count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_count <= '0;
        end else if (validJump && (taken_count != '1)) begin
            taken_count <= taken_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_jump_control.sv
// Directed-vector bench for jump_control.
// Stats checks are compiled in when JUMP_CONTROL_STATS_EN is defined.
module tb_jump_control;
    import jump_control_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero, sign, carry, stall;
    logic       validJump, is_branch, validJump_q;
`ifdef JUMP_CONTROL_STATS_EN
    logic [15:0] taken_count;
    logic [1:0]  taken_count2;
    logic        vj2, br2, vjq2;
`endif

    int total;
    int bad;

    jump_control dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .sign        (sign),
        .carry       (carry),
        .stall       (stall),
        .validJump   (validJump),
        .is_branch   (is_branch),
`ifdef JUMP_CONTROL_STATS_EN
        .taken_count (taken_count),
`endif
        .validJump_q (validJump_q)
    );

`ifdef JUMP_CONTROL_STATS_EN
    jump_control #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .sign        (sign),
        .carry       (carry),
        .stall       (stall),
        .validJump   (vj2),
        .is_branch   (br2),
        .taken_count (taken_count2),
        .validJump_q (vjq2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       z;
        logic       s;
        logic       c;
        logic       st;
        logic       vj;
        logic       br;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void add(input logic [5:0] op,
                                input logic z, input logic s,
                                input logic c, input logic st,
                                input logic vj, input logic br);
        vec_t v;
        v.op = op; v.z = z; v.s = s; v.c = c;
        v.st = st; v.vj = vj; v.br = br;
        vecs.push_back(v);
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        //    op         z  s  c  st vj br
        add(6'b000111, 0, 1, 0, 0, 1, 1);
        add(6'b000111, 0, 0, 0, 0, 0, 1);
        add(6'b001000, 1, 0, 0, 0, 1, 1);
        add(6'b001010, 1, 0, 0, 0, 0, 1);
        add(6'b001010, 0, 0, 0, 0, 1, 1);
        add(6'b001101, 0, 0, 1, 0, 1, 1);
        add(6'b001110, 0, 0, 1, 0, 0, 1);
        add(6'b001110, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++)
            add(6'b000110, i[0], i[1], i[2], 0, 1, 1);
        add(6'b000000, 1, 1, 1, 0, 0, 0);
        add(6'b000101, 0, 0, 0, 0, 1, 1);
        add(6'b001001, 0, 0, 0, 0, 1, 1);
        add(6'b001011, 0, 0, 0, 0, 1, 1);
        add(6'b001011, 1, 0, 0, 0, 0, 1);
        add(6'b001011, 0, 1, 0, 0, 0, 1);
        add(6'b001100, 1, 0, 1, 0, 1, 1);
        add(6'b001100, 0, 1, 0, 0, 0, 1);
        add(6'b001000, 0, 1, 1, 0, 0, 1);
        add(6'b000101, 1, 1, 1, 1, 0, 1);
        add(6'b111111, 1, 1, 1, 0, 0, 0);
        add(6'b000100, 1, 1, 1, 0, 0, 0);
        add(6'b001111, 1, 1, 1, 0, 0, 0);
        add(6'b000111, 1, 1, 1, 0, 1, 1);

        rst_n  = 1'b0;
        opcode = 6'b000000;
        zero   = 1'b0;
        sign   = 1'b0;
        carry  = 1'b0;
        stall  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_vjq", 32'(validJump_q), 32'd0);
`ifdef JUMP_CONTROL_STATS_EN
        chk("reset_cnt", 32'(taken_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            sign   = vecs[i].s;
            carry  = vecs[i].c;
            stall  = vecs[i].st;
            #1;
            chk($sformatf("vj[%0d]", i), 32'(validJump),
                32'(vecs[i].vj));
            chk($sformatf("br[%0d]", i), 32'(is_branch),
                32'(vecs[i].br));
            @(posedge clk);
            #1;
            chk($sformatf("vjq[%0d]", i), 32'(validJump_q),
                32'(vecs[i].vj));
        end

        // stall, release, then reset while the branch stays taken
        @(negedge clk);
        opcode = OP_BZ;
        zero   = 1'b1;
        sign   = 1'b0;
        carry  = 1'b0;
        stall  = 1'b1;
        #1;
        chk("stall_vj", 32'(validJump), 32'd0);
        chk("stall_br", 32'(is_branch), 32'd1);
        @(posedge clk);
        #1;
        chk("stall_vjq", 32'(validJump_q), 32'd0);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("go_vj", 32'(validJump), 32'd1);
        @(posedge clk);
        #1;
        chk("go_vjq", 32'(validJump_q), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vjq", 32'(validJump_q), 32'd0);
        chk("rst_vj", 32'(validJump), 32'd1);
        chk("rst_br", 32'(is_branch), 32'd1);

`ifdef JUMP_CONTROL_STATS_EN
        chk("rst_cnt", 32'(taken_count), 32'd0);
        chk("rst_cnt2", 32'(taken_count2), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        opcode = OP_B;
        repeat (5) @(posedge clk);
        @(negedge clk);
        opcode = 6'b000000;
        #1;
        chk("cnt5", 32'(taken_count), 32'd5);
        chk("cnt2_sat", 32'(taken_count2), 32'd3);
        @(posedge clk);
        #1;
        chk("cnt_hold", 32'(taken_count), 32'd5);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_clr", 32'(taken_count), 32'd0);
        chk("cnt2_clr", 32'(taken_count2), 32'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
